fpadd_arbiter: RTL and testbench

- Round-robin scheduler sharing one fixed-point/float adder datapath (adder + control FSM) among NREQ requesters.
- Accepts one operand pair at a time, pulses Go to the adder and waits for FlagResult. Returns the result to the granted requester.
- A watchdog aborts a hung operation.
- Sits between requester front-ends and the adder top level; it is the adder's only source of Go.

---
 rtl/fpadd_arbpkg.sv | 18 +
 rtl/fpadd_arbiter_rr_pick.sv | 34 +++
 rtl/fpadd_arbiter.sv | 156 +++++++++++++++
 tb/tb_fpadd_arbiter.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpadd_arbpkg.sv
// Shared types and width helpers for the round-robin adder arbiter.
package fpadd_arbpkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} ArbStateType;

  function automatic int calc_w(input int expbits, input int mbits);
    return 1 + expbits + mbits;
  endfunction

  function automatic int wd_width(input int timeout);
    return $clog2(timeout);
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fpadd_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid request after the last grant.
module rr_pick
  import fpadd_arbpkg::*;
#(
  parameter int NREQ = 4,
  parameter int IW   = idx_width(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IW-1:0]   i_last,
  output logic [IW-1:0]   o_grant,
  output logic            o_any
);

  int w_best;

  // Distance 0 is the index immediately after the last grant.
  function automatic int rr_dist(input int idx, input logic [IW-1:0] last);
    return (idx + NREQ - 1 - int'(last)) % NREQ;
  endfunction

  always_comb begin
    o_grant = '0;
    o_any   = 1'b0;
    w_best  = NREQ;
    for (int i = 0; i < NREQ; i++) begin
      if (i_req[i] && (rr_dist(i, i_last) < w_best)) begin
        w_best  = rr_dist(i, i_last);
        o_grant = IW'(i);
        o_any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fpadd_arbiter.sv
// Round-robin scheduler sharing one adder among NREQ requesters, with a
// watchdog that aborts an operation whose result never arrives.
module fpadd_arbiter
  import fpadd_arbpkg::*;
#(
  parameter int NREQ         = 4,
  parameter int EXPBITS      = 8,
  parameter int MANTISSABITS = 23,
  parameter int TIMEOUT      = 64,
  localparam int W           = calc_w(EXPBITS, MANTISSABITS)
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [NREQ-1:0]   ReqValid,
  input  logic [NREQ*W-1:0] ReqA,
  input  logic [NREQ*W-1:0] ReqB,
  output logic [NREQ-1:0]   ReqReady,
  output logic [NREQ-1:0]   RespValid,
  output logic [W-1:0]      RespResult,
  output logic              RespError,
  output logic [W-1:0]      AddA,
  output logic [W-1:0]      AddB,
  output logic              Go,
  input  logic              FlagResult,
  input  logic [W-1:0]      AddResult,
  output logic              Busy
);

  localparam int IW  = idx_width(NREQ);
  localparam int WDW = wd_width(TIMEOUT);

  ArbStateType      r_state;
  ArbStateType      w_state_nxt;
  logic [IW-1:0]    r_grant;
  logic [IW-1:0]    r_last;
  logic [IW-1:0]    w_pick;
  logic             w_any;
  logic [WDW-1:0]   r_wd;
  logic             w_timeout;
  logic [W-1:0]     r_add_a;
  logic [W-1:0]     r_add_b;
  logic [W-1:0]     r_result;
  logic             r_error;
  logic [W-1:0]     w_sel_a;
  logic [W-1:0]     w_sel_b;

  function automatic logic [NREQ-1:0] onehot(input logic [IW-1:0] idx);
    logic [NREQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .i_req   (ReqValid),
    .i_last  (r_last),
    .o_grant (w_pick),
    .o_any   (w_any)
  );

  always_comb begin
    w_sel_a = '0;
    w_sel_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_pick == IW'(i)) begin
        w_sel_a = ReqA[i*W +: W];
        w_sel_b = ReqB[i*W +: W];
      end
    end
  end

  assign w_timeout = (r_wd == WDW'(TIMEOUT - 1));

  always_ff @(posedge Clock) begin
    if (Reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Strobes are suppressed while Reset is high so nothing is accepted or
  // returned in a cycle whose state update is being discarded.
  always_comb begin
    w_state_nxt = r_state;
    ReqReady    = '0;
    RespValid   = '0;
    Go          = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_state_nxt = ISSUE;
          ReqReady    = onehot(w_pick);
        end
      end
      ISSUE: begin
        w_state_nxt = WAIT;
        Go          = 1'b1;
      end
      WAIT: begin
        if (FlagResult || w_timeout) w_state_nxt = RESP;
      end
      RESP: begin
        w_state_nxt = IDLE;
        RespValid   = onehot(r_grant);
      end
      default: w_state_nxt = IDLE;
    endcase
    Busy = (r_state != IDLE);
    if (Reset) begin
      ReqReady  = '0;
      RespValid = '0;
      Go        = 1'b0;
      Busy      = 1'b0;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_grant  <= '0;
      r_last   <= IW'(NREQ - 1);
      r_wd     <= '0;
      r_add_a  <= '0;
      r_add_b  <= '0;
      r_result <= '0;
      r_error  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_grant <= w_pick;
            r_add_a <= w_sel_a;
            r_add_b <= w_sel_b;
          end
        end
        ISSUE: r_wd <= '0;
        WAIT: begin
          r_wd <= r_wd + 1'b1;
          // A result on the timeout cycle still counts as success.
          if (FlagResult) begin
            r_result <= AddResult;
            r_error  <= 1'b0;
          end else if (w_timeout) begin
            r_result <= '0;
            r_error  <= 1'b1;
          end
        end
        RESP: r_last <= r_grant;
        default: ;
      endcase
    end
  end

  assign AddA       = r_add_a;
  assign AddB       = r_add_b;
  assign RespResult = r_result;
  assign RespError  = r_error;

endmodule

// File: tb/tb_fpadd_arbiter.sv
// Directed scoreboard bench for fpadd_arbiter with a scripted adder model.
module tb_fpadd_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 32;

  logic              Clock;
  logic              Reset;
  logic [NREQ-1:0]   ReqValid;
  logic [NREQ*W-1:0] ReqA;
  logic [NREQ*W-1:0] ReqB;
  logic [NREQ-1:0]   ReqReady;
  logic [NREQ-1:0]   RespValid;
  logic [W-1:0]      RespResult;
  logic              RespError;
  logic [W-1:0]      AddA;
  logic [W-1:0]      AddB;
  logic              Go;
  logic              FlagResult;
  logic [W-1:0]      AddResult;
  logic              Busy;

  logic m_flag;
  logic t_flag;
  assign FlagResult = m_flag | t_flag;

  fpadd_arbiter #(.NREQ(4), .EXPBITS(8), .MANTISSABITS(23), .TIMEOUT(64)) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .ReqValid   (ReqValid),
    .ReqA       (ReqA),
    .ReqB       (ReqB),
    .ReqReady   (ReqReady),
    .RespValid  (RespValid),
    .RespResult (RespResult),
    .RespError  (RespError),
    .AddA       (AddA),
    .AddB       (AddB),
    .Go         (Go),
    .FlagResult (FlagResult),
    .AddResult  (AddResult),
    .Busy       (Busy)
  );

  typedef struct {
    int          idx;
    logic [31:0] res;
    logic        err;
  } sb_t;

  sb_t  sb[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   resp_count = 0;
  int   go_count = 0;
  logic mon_en = 1'b0;
  logic adder_on = 1'b1;
  int   adder_delay = 2;

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] oh(input int i);
    logic [3:0] v;
    v = 4'b0001 << i;
    return v;
  endfunction

  // Stand-in adder: integer sum of the bit patterns, except the 1.0 + 2.0
  // directed vector which returns 3.0.
  function automatic logic [31:0] fake_sum(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h3F80_0000 && b == 32'h4000_0000) return 32'h4040_0000;
    return a + b;
  endfunction

  function automatic sb_t mk(input int idx, input logic [31:0] res, input logic err);
    sb_t e;
    e.idx = idx;
    e.res = res;
    e.err = err;
    return e;
  endfunction

  task automatic set_ops(input int r, input logic [31:0] a, input logic [31:0] b);
    ReqA[r*W +: W] = a;
    ReqB[r*W +: W] = b;
  endtask

  // Adder model: raises FlagResult adder_delay cycles after it sees Go.
  initial begin
    logic [31:0] a;
    logic [31:0] b;
    m_flag    = 1'b0;
    AddResult = '0;
    forever begin
      @(posedge Clock); #1;
      if (adder_on && Go === 1'b1) begin
        a = AddA;
        b = AddB;
        repeat (adder_delay) @(posedge Clock);
        #1;
        m_flag    = 1'b1;
        AddResult = fake_sum(a, b);
        @(posedge Clock); #1;
        m_flag = 1'b0;
      end
    end
  end

  // Response monitor / scoreboard checker.
  initial begin
    sb_t e;
    forever begin
      @(posedge Clock); #3;
      if (mon_en) begin
        chk("rdy_onehot0", 64'($onehot0(ReqReady)), 64'd1);
        if (Go === 1'b1) go_count++;
        if (RespValid !== '0) begin
          if (sb.size() == 0) begin
            chk("resp_unexpected", 64'(RespValid), 64'd0);
          end else begin
            e = sb.pop_front();
            chk("resp_valid", 64'(RespValid), 64'(oh(e.idx)));
            chk("resp_result", 64'(RespResult), 64'(e.res));
            chk("resp_error", 64'(RespError), 64'(e.err));
            resp_count++;
          end
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  task automatic wait_resp(input int target);
    int n;
    n = 0;
    while (resp_count < target && n < 300) begin
      @(posedge Clock); #2;
      n++;
    end
    chk("resp_count", 64'(resp_count), 64'(target));
  endtask

  task automatic one_op(input int r, input logic [31:0] a, input logic [31:0] b,
                        input int dly, input logic on, input int exp_lat,
                        input logic [31:0] exp_res, input logic exp_err);
    int c0;
    int n;
    adder_delay = dly;
    adder_on    = on;
    @(posedge Clock); #1;
    set_ops(r, a, b);
    ReqValid = oh(r);
    sb.push_back(mk(r, exp_res, exp_err));
    #1;
    chk("accept_rdy", 64'(ReqReady), 64'(oh(r)));
    chk("accept_go", 64'(Go), 64'd0);
    c0 = cyc;
    @(posedge Clock); #1;
    ReqValid = '0;
    #1;
    chk("issue_go", 64'(Go), 64'd1);
    chk("issue_adda", 64'(AddA), 64'(a));
    chk("issue_addb", 64'(AddB), 64'(b));
    @(posedge Clock); #2;
    chk("wait_go_low", 64'(Go), 64'd0);
    chk("wait_busy", 64'(Busy), 64'd1);
    n = 0;
    while (RespValid === '0 && n < 200) begin
      @(posedge Clock); #2;
      n++;
    end
    chk("latency", 64'(cyc - c0), 64'(exp_lat));
  endtask

  initial begin
    int g;
    int n;
    int go0;
    int ng;
    int ngo;
    int tg0;
    int tg1;
    int tgo;
    int base;
    Reset    = 1'b1;
    ReqValid = 4'b1111;
    ReqA     = '0;
    ReqB     = '0;
    t_flag   = 1'b0;

    // Reset: every output low, even with all requests asserted.
    @(posedge Clock); #1;
    @(posedge Clock); #2;
    chk("rst_busy", 64'(Busy), 64'd0);
    chk("rst_go", 64'(Go), 64'd0);
    chk("rst_rdy", 64'(ReqReady), 64'd0);
    chk("rst_resp", 64'(RespValid), 64'd0);
    chk("rst_adda", 64'(AddA), 64'd0);
    chk("rst_addb", 64'(AddB), 64'd0);
    chk("rst_result", 64'(RespResult), 64'd0);
    chk("rst_error", 64'(RespError), 64'd0);
    @(posedge Clock); #1;
    Reset    = 1'b0;
    ReqValid = '0;
    mon_en   = 1'b1;

    // All four requesting: grants rotate 0,1,2,3,0,1,2,3.
    adder_on    = 1'b1;
    adder_delay = 2;
    for (int i = 0; i < 4; i++) set_ops(i, 32'h0100_0000 * (i + 1), 32'h0000_0100 * (i + 1) + i);
    for (int k = 0; k < 8; k++)
      sb.push_back(mk(k % 4, fake_sum(32'h0100_0000 * (k % 4 + 1), 32'h0000_0100 * (k % 4 + 1) + k % 4), 1'b0));
    go0  = go_count;
    base = resp_count;
    @(posedge Clock); #1;
    ReqValid = 4'b1111;
    g = 0;
    n = 0;
    while (g < 8 && n < 400) begin
      #1;
      if (ReqReady !== '0) begin
        chk("rr_grant", 64'(ReqReady), 64'(oh(g % 4)));
        g++;
      end
      n++;
      @(posedge Clock); #1;
      if (g == 8) ReqValid = '0;
    end
    ReqValid = '0;
    chk("rr_grants", 64'(g), 64'd8);
    wait_resp(base + 8);
    chk("rr_go_count", 64'(go_count - go0), 64'd8);

    // Single request 1.0 + 2.0, result 5 cycles after Go.
    one_op(0, 32'h3F80_0000, 32'h4000_0000, 5, 1'b1, 7, 32'h4040_0000, 1'b0);

    // Adder never answers: abort after 64 WAIT cycles, then a normal op.
    one_op(1, 32'h1111_0000, 32'h0000_2222, 1, 1'b0, 66, 32'h0, 1'b1);
    one_op(3, 32'h0A0B_0000, 32'h0000_0C0D, 3, 1'b1, 5, fake_sum(32'h0A0B_0000, 32'h0000_0C0D), 1'b0);

    // Stray FlagResult while idle is ignored.
    adder_on = 1'b0;
    @(posedge Clock); #1;
    t_flag = 1'b1;
    @(posedge Clock); #1;
    t_flag = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("idle_flag_busy", 64'(Busy), 64'd0);
      chk("idle_flag_resp", 64'(RespValid), 64'd0);
      @(posedge Clock); #1;
    end

    // Lone requester 2 is re-granted right after its response.
    adder_on    = 1'b1;
    adder_delay = 1;
    set_ops(2, 32'h0000_7000, 32'h0000_0007);
    sb.push_back(mk(2, fake_sum(32'h0000_7000, 32'h0000_0007), 1'b0));
    sb.push_back(mk(2, fake_sum(32'h0000_7000, 32'h0000_0007), 1'b0));
    base = resp_count;
    @(posedge Clock); #1;
    ReqValid = 4'b0100;
    ng  = 0;
    ngo = 0;
    tg0 = 0;
    tg1 = 0;
    tgo = 0;
    for (int k = 0; k < 12; k++) begin
      #1;
      if (ReqReady !== '0) begin
        chk("solo_rdy", 64'(ReqReady), 64'(4'b0100));
        if (ng == 0) tg0 = cyc;
        else         tg1 = cyc;
        ng++;
      end
      if (Go === 1'b1) begin
        if (ngo == 0) tgo = cyc;
        ngo++;
      end
      @(posedge Clock); #1;
      if (ng >= 2) ReqValid = '0;
    end
    ReqValid = '0;
    chk("solo_grants", 64'(ng), 64'd2);
    chk("solo_regrant_gap", 64'(tg1 - tg0), 64'd4);
    chk("solo_go_at", 64'(tgo - tg0), 64'd1);
    chk("solo_go_cycles", 64'(ngo), 64'd2);
    wait_resp(base + 2);

    // Reset during WAIT; the late FlagResult must be ignored.
    adder_on = 1'b0;
    set_ops(2, 32'h0000_0055, 32'h0000_0066);
    @(posedge Clock); #1;
    ReqValid = 4'b0100;
    @(posedge Clock); #1;
    ReqValid = '0;
    @(posedge Clock); #1;
    @(posedge Clock); #2;
    chk("abort_busy_wait", 64'(Busy), 64'd1);
    Reset = 1'b1;
    @(posedge Clock); #1;
    Reset = 1'b0;
    #1;
    chk("abort_busy_rst", 64'(Busy), 64'd0);
    @(posedge Clock); #1;
    t_flag = 1'b1;
    @(posedge Clock); #1;
    t_flag = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("abort_busy", 64'(Busy), 64'd0);
      chk("abort_resp", 64'(RespValid), 64'd0);
      @(posedge Clock); #1;
    end
    adder_on    = 1'b1;
    adder_delay = 2;
    for (int i = 0; i < 4; i++) set_ops(i, 32'h0200_0000 + i, 32'h0000_0300);
    sb.push_back(mk(0, fake_sum(32'h0200_0000, 32'h0000_0300), 1'b0));
    base = resp_count;
    ReqValid = 4'b1111;
    #1;
    chk("post_abort_grant", 64'(ReqReady), 64'(4'b0001));
    @(posedge Clock); #1;
    ReqValid = '0;
    wait_resp(base + 1);
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
